// File: rtl/rptr_sync_empty_if.sv
// Read-side FIFO pointer bundle: Gray write pointer in, read request in,
// read pointer, RAM address, level and status flags out.
interface rptr_sync_empty_if #(
  parameter int ADDR_WIDTH = 4
);
  // Handshake: a read completes on a rising rclk edge where rinc=1 and rempty=0.
  // rinc while rempty=1 is dropped. rempty is the inverse of "ready".
  logic [ADDR_WIDTH:0]   wptr;
  logic                  rinc;
  logic [ADDR_WIDTH:0]   rptr;
  logic [ADDR_WIDTH-1:0] raddr;
  logic                  rempty;
  logic                  raempty;
  logic [ADDR_WIDTH:0]   rcount;
  logic                  rgray_err;

  modport master (
    output wptr, rinc,
    input  rptr, raddr, rempty, raempty, rcount, rgray_err
  );

  modport slave (
    input  wptr, rinc,
    output rptr, raddr, rempty, raempty, rcount, rgray_err
  );
endinterface

// File: rtl/rptr_sync_empty.sv
// Async-FIFO read-side controller: write-pointer synchronizer, Gray read pointer,
// empty/almost-empty flags and fill level. Optional macro: WPTR_GRAY_CHECK_EN.
module rptr_sync_empty #(
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AEMPTY_TH   = 2
) (
  input  logic rclk,
  input  logic rrst_n,
  rptr_sync_empty_if.slave rif
);
  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AE_TH = PW'(AEMPTY_TH);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
    $error("SYNC_STAGES must be in 2..4");
  end
  if (AEMPTY_TH < 1 || AEMPTY_TH > (2**ADDR_WIDTH) - 1) begin : g_bad_th
    $error("AEMPTY_TH out of range");
  end

  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] sync_d [SYNC_STAGES];
  logic [PW-1:0] rq_wptr;
  logic [PW-1:0] wbin_s;
  logic [PW-1:0] rbin_q, rbin_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] rcount_q, rcount_d;
  logic          rempty_q, rempty_d;
  logic          raempty_q, raempty_d;
  logic          accepted;

  always_comb begin
    sync_d[0] = rif.wptr;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign rq_wptr = sync_q[SYNC_STAGES-1];

  always_comb begin
    wbin_s = '0;
    for (int i = 0; i < PW; i++) begin
      wbin_s[i] = ^(rq_wptr >> i);
    end
  end

  always_comb begin
    accepted  = rif.rinc & ~rempty_q;
    rbin_d    = rbin_q + {{ADDR_WIDTH{1'b0}}, accepted};
    rptr_d    = (rbin_d >> 1) ^ rbin_d;
    // Compare the full Gray value so a full FIFO (MSB differs) is never empty.
    rempty_d  = (rptr_d == rq_wptr);
    rcount_d  = wbin_s - rbin_d;
    raempty_d = (rcount_d <= AE_TH);
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      rbin_q    <= '0;
      rptr_q    <= '0;
      rcount_q  <= '0;
      rempty_q  <= 1'b1;
      raempty_q <= 1'b1;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      rbin_q    <= rbin_d;
      rptr_q    <= rptr_d;
      rcount_q  <= rcount_d;
      rempty_q  <= rempty_d;
      raempty_q <= raempty_d;
    end
  end

  assign rif.rptr    = rptr_q;
  assign rif.raddr   = rbin_q[ADDR_WIDTH-1:0];
  assign rif.rempty  = rempty_q;
  assign rif.raempty = raempty_q;
  assign rif.rcount  = rcount_q;

`ifdef WPTR_GRAY_CHECK_EN
  localparam logic [PW-1:0] DEPTH = PW'(2**ADDR_WIDTH);

  logic [PW-1:0] rq_prev_q, rq_prev_d;
  logic [PW-1:0] flips;
  logic [PW-1:0] occupancy;
  logic          rgray_err_q, rgray_err_d;

  always_comb begin
    rq_prev_d   = rq_wptr;
    flips       = rq_wptr ^ rq_prev_q;
    occupancy   = wbin_s - rbin_q;
    // x & (x-1) is non-zero exactly when more than one bit flipped.
    rgray_err_d = rgray_err_q
                | ((flips & (flips - 1'b1)) != '0)
                | (occupancy > DEPTH);
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rq_prev_q   <= '0;
      rgray_err_q <= 1'b0;
    end else begin
      rq_prev_q   <= rq_prev_d;
      rgray_err_q <= rgray_err_d;
    end
  end

  assign rif.rgray_err = rgray_err_q;
`else
  assign rif.rgray_err = 1'b0;
`endif
endmodule

// File: tb/tb_rptr_sync_empty.sv
// Directed bench for rptr_sync_empty (ADDR_WIDTH=4, SYNC_STAGES=2, AEMPTY_TH=2).
module tb_rptr_sync_empty;
  localparam int AW = 4;
  localparam int SS = 2;
`ifdef WPTR_GRAY_CHECK_EN
  localparam logic GCHK = 1'b1;
`else
  localparam logic GCHK = 1'b0;
`endif

  logic rclk;
  logic rrst_n;
  logic [AW:0] wbin;
  int n_checks;
  int n_fail;

  rptr_sync_empty_if #(.ADDR_WIDTH(AW)) rif ();

  rptr_sync_empty #(
    .ADDR_WIDTH (AW),
    .SYNC_STAGES(SS),
    .AEMPTY_TH  (2)
  ) dut (
    .rclk  (rclk),
    .rrst_n(rrst_n),
    .rif   (rif)
  );

  // clock / reset
  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  function automatic logic [AW:0] gray(input logic [AW:0] b);
    return (b >> 1) ^ b;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver tasks: inputs change on the falling edge, outputs sampled there too
  task automatic step();
    @(negedge rclk);
  endtask

  task automatic settle();
    repeat (SS + 1) step();
  endtask

  task automatic push(input int n);
    for (int i = 0; i < n; i++) begin
      wbin = wbin + 1'b1;
      rif.wptr = gray(wbin);
      step();
    end
  endtask

  task automatic read(input int n);
    rif.rinc = 1'b1;
    repeat (n) step();
    rif.rinc = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rrst_n   = 1'b0;
    wbin     = '0;
    rif.wptr = 5'b00011;
    rif.rinc = 1'b0;
    repeat (3) step();

    // reset values
    check("rst_rempty",  32'(rif.rempty),    32'd1);
    check("rst_raempty", 32'(rif.raempty),   32'd1);
    check("rst_rcount",  32'(rif.rcount),    32'd0);
    check("rst_rptr",    32'(rif.rptr),      32'd0);
    check("rst_raddr",   32'(rif.raddr),     32'd0);
    check("rst_gerr",    32'(rif.rgray_err), 32'd0);

    rif.wptr = '0;
    rrst_n   = 1'b1;
    repeat (2) step();

    // latency: write becomes visible SYNC_STAGES+1 edges later, never earlier
    wbin = 5'd1;
    rif.wptr = gray(wbin);
    repeat (2) step();
    check("lat_early_rempty", 32'(rif.rempty), 32'd1);
    step();
    check("lat_rempty", 32'(rif.rempty), 32'd0);
    check("lat_rcount", 32'(rif.rcount), 32'd1);
    check("lat_raempty", 32'(rif.raempty), 32'd1);
    read(1);
    check("rd1_rempty", 32'(rif.rempty), 32'd1);
    check("rd1_rptr",   32'(rif.rptr),   32'b00001);
    check("rd1_raddr",  32'(rif.raddr),  32'd1);
    check("rd1_rcount", 32'(rif.rcount), 32'd0);

    // read while empty is ignored
    read(4);
    check("rwe_rptr",   32'(rif.rptr),   32'b00001);
    check("rwe_raddr",  32'(rif.raddr),  32'd1);
    check("rwe_rcount", 32'(rif.rcount), 32'd0);
    check("rwe_rempty", 32'(rif.rempty), 32'd1);

    // almost-empty threshold
    push(3);
    settle();
    check("ae3_rcount",  32'(rif.rcount),  32'd3);
    check("ae3_raempty", 32'(rif.raempty), 32'd0);
    check("ae3_rempty",  32'(rif.rempty),  32'd0);
    read(1);
    check("ae2_rcount",  32'(rif.rcount),  32'd2);
    check("ae2_raempty", 32'(rif.raempty), 32'd1);
    check("ae2_rptr",    32'(rif.rptr),    32'b00011);

    // synchronized write arrives in the same cycle as a read
    wbin = 5'd5;
    rif.wptr = gray(wbin);
    repeat (2) step();
    read(1);
    check("sim_rcount", 32'(rif.rcount), 32'd2);
    check("sim_rptr",   32'(rif.rptr),   32'b00010);
    check("sim_rempty", 32'(rif.rempty), 32'd0);

    // asynchronous reset mid-operation
    #2;
    rrst_n   = 1'b0;
    rif.wptr = '0;
    wbin     = '0;
    #1;
    check("arst_rptr",    32'(rif.rptr),    32'd0);
    check("arst_rcount",  32'(rif.rcount),  32'd0);
    check("arst_rempty",  32'(rif.rempty),  32'd1);
    check("arst_raempty", 32'(rif.raempty), 32'd1);
    step();
    rrst_n = 1'b1;
    step();

    // wrap-around: fill, drain, fill again (full is not empty)
    push(16);
    settle();
    check("full1_rcount", 32'(rif.rcount), 32'd16);
    check("full1_rempty", 32'(rif.rempty), 32'd0);
    read(16);
    check("wrap_rptr",   32'(rif.rptr),   32'b11000);
    check("wrap_raddr",  32'(rif.raddr),  32'd0);
    check("wrap_rempty", 32'(rif.rempty), 32'd1);
    check("wrap_rcount", 32'(rif.rcount), 32'd0);
    push(16);
    settle();
    check("full2_rcount",  32'(rif.rcount),  32'd16);
    check("full2_rempty",  32'(rif.rempty),  32'd0);
    check("full2_raempty", 32'(rif.raempty), 32'd0);
    check("full2_gerr",    32'(rif.rgray_err), 32'd0);

    // illegal Gray jump 00000 -> 00011
    rrst_n = 1'b0;
    rif.wptr = '0;
    wbin = '0;
    step();
    rrst_n = 1'b1;
    step();
    rif.wptr = 5'b00011;
    repeat (SS) step();
    check("gerr_early", 32'(rif.rgray_err), 32'd0);
    step();
    check("gerr_set", 32'(rif.rgray_err), 32'(GCHK));
    repeat (5) step();
    check("gerr_hold", 32'(rif.rgray_err), 32'(GCHK));
    rrst_n = 1'b0;
    #1;
    check("gerr_clr", 32'(rif.rgray_err), 32'd0);
    step();
    rrst_n = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rptr_sync_empty.md
RPTR_SYNC_EMPTY -- requirements
Module: rptr_sync_empty

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, FIFO address width; depth = 2^ADDR_WIDTH.
REQ-002 Parameter SYNC_STAGES, default 2, number of write-pointer synchronizer flops; legal range 2..4.
REQ-003 Parameter AEMPTY_TH, default 2, almost-empty threshold in entries; legal range 1..2^ADDR_WIDTH-1.
REQ-004 rclk  input  1  read-domain clock; all state updates on rising edge.
REQ-005 rrst_n  input  1  reset, asynchronous, active-low.
REQ-006 wptr  input  ADDR_WIDTH+1  write pointer, Gray-coded, from the write-clock domain.
REQ-007 rinc  input  1  read request; one entry consumed per cycle when accepted.
REQ-008 rptr  output  ADDR_WIDTH+1  registered read pointer, Gray-coded, to the write domain.
REQ-009 raddr  output  ADDR_WIDTH  binary read address to RAM = low ADDR_WIDTH bits of binary read pointer.
REQ-010 rempty  output  1  registered empty flag.
REQ-011 raempty  output  1  registered almost-empty flag.
REQ-012 rcount  output  ADDR_WIDTH+1  registered fill level seen from the read domain, 0..2^ADDR_WIDTH.
REQ-013 rgray_err  output  1  sticky Gray-violation flag (see Configuration).

Function
REQ-014 wptr shall pass through a chain of SYNC_STAGES flops clocked by rclk; the last stage is rq_wptr; no logic between stages.
REQ-015 rq_wptr shall be converted Gray-to-binary (wbin_s) combinationally in the read domain.
REQ-016 Read accepted = rinc AND NOT rempty; rinc while rempty shall be ignored, no pointer change.
REQ-017 rbin_next = rbin + accepted, modulo 2^(ADDR_WIDTH+1); rgray_next = (rbin_next >> 1) XOR rbin_next; both registered each cycle into rbin and rptr.
REQ-018 rempty shall register (rgray_next == rq_wptr), so the last read asserts rempty on the same edge that advances rptr.
REQ-019 rcount shall register (wbin_s - rbin_next) modulo 2^(ADDR_WIDTH+1).
REQ-020 raempty shall register ((wbin_s - rbin_next) mod 2^(ADDR_WIDTH+1)) <= AEMPTY_TH.
REQ-021 Latency: a wptr change stable at the input shall reach rq_wptr after SYNC_STAGES rising edges and appear on rempty/rcount/raempty one edge later (SYNC_STAGES+1 total).
REQ-022 Wrap-around: pointer MSB toggles on each pass through the address space; rempty shall compare all ADDR_WIDTH+1 bits so a full FIFO (MSB differs, rest equal) is never flagged empty.
REQ-023 Simultaneous read and synchronized write arrival in one cycle: rcount shall reflect both (net unchanged for one of each).
REQ-024 rempty deassertion is pessimistic: it may lag the true write by up to SYNC_STAGES+1 cycles; never early.

Reset
REQ-025 While rrst_n low: all synchronizer stages, rbin, rptr, rcount = 0; rempty = 1; raempty = 1; rgray_err = 0.
REQ-026 Reset assertion mid-operation shall immediately (asynchronously) force the REQ-025 values, discarding in-flight pointer samples.
REQ-027 Reset release shall be synchronous to rclk by the integrating level; the block adds no release synchronizer.

Configuration
REQ-028 Macro WPTR_GRAY_CHECK_EN: when defined, rgray_err shall set on any cycle where rq_wptr differs from its previous-cycle value in more than one bit, or where (wbin_s - rbin) mod 2^(ADDR_WIDTH+1) exceeds 2^ADDR_WIDTH; once set it holds until reset.
REQ-029 When WPTR_GRAY_CHECK_EN is not defined, rgray_err shall be driven constant 0 and no check logic or history register shall be synthesized; all other behaviour identical.

Verification
REQ-030 Reset: rrst_n low, wptr=5'b00011 -> rempty=1, raempty=1, rcount=0, rptr=0, raddr=0.
REQ-031 Latency (SYNC_STAGES=2): wptr 0->1 Gray at edge N -> rempty falls, rcount=1 at edge N+3; rinc=1 at next cycle -> rempty=1, rptr=5'b00001, raddr=1.
REQ-032 Read-while-empty: rempty=1, rinc=1 for 4 cycles -> rptr, raddr, rcount unchanged.
REQ-033 Wrap (ADDR_WIDTH=4): drive 16 writes, read 16 -> rptr=5'b11000 (binary 16), rempty=1; 16 more writes -> rcount=16, rempty=0 (full not empty).
REQ-034 Almost-empty (AEMPTY_TH=2): rcount 3 -> raempty=0; one read -> rcount=2, raempty=1.
REQ-035 With WPTR_GRAY_CHECK_EN: wptr jumps 5'b00000->5'b00011 -> rgray_err=1 SYNC_STAGES+1 edges later, stays 1 until rrst_n low; without macro rgray_err stays 0.
